// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised sequence detector.
// The helpers build the detector's next-state tables from the target pattern.
package seq_detect_pkg;

    localparam int         DEFAULT_SEQ_LEN = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input logic [15:0] pat, input int len, input int i);
        return pat[len-1-i];
    endfunction

    // Longest k <= max_k such that the first k pattern bits equal the last k bits of
    // the window formed by the first s pattern bits followed by b.
    function automatic int border_len(input logic [15:0] pat, input int len, input int s,
                                      input logic b, input int max_k);
        int   res;
        int   j;
        logic ok;
        logic wb;
        res = 0;
        for (int k = 1; k <= max_k; k++) begin
            ok = 1'b1;
            for (int t = 0; t < k; t++) begin
                j  = s + 1 - k + t;
                wb = (j < s) ? pat_bit(pat, len, j) : b;
                if (wb != pat_bit(pat, len, t)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = k;
            end
        end
        return res;
    endfunction

    function automatic int next_state(input logic [15:0] pat, input int len, input int s,
                                      input logic b);
        int max_k;
        max_k = (s + 1 < len) ? s + 1 : len - 1;
        return border_len(pat, len, s, b, max_k);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int failure_len(input logic [15:0] pat, input int len);
        return border_len(pat, len, len - 1, pat_bit(pat, len, len - 1), len - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: full-DFA prefix tracking with a Mealy match flag and
// a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      din,
    input  logic                      clr_cnt,
    output logic                      dout,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [clog2(SEQ_LEN)-1:0] state_o
);

    localparam int             SW      = clog2(SEQ_LEN);
    localparam int             TAB_N   = 1 << SW;
    localparam logic [SW-1:0]  LAST    = SW'(SEQ_LEN - 1);
    localparam logic [SW-1:0]  FAIL_ST = SW'(failure_len(16'(PATTERN), SEQ_LEN));

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] nxt0    [TAB_N];
    logic [SW-1:0] nxt1    [TAB_N];
    logic          exp_tab [TAB_N];

    // Tables are padded to a power of two so any state_q value indexes safely.
    for (genvar g = 0; g < TAB_N; g++) begin : g_tab
        if (g < SEQ_LEN) begin : g_live
            localparam int N0 = next_state(16'(PATTERN), SEQ_LEN, g, 1'b0);
            localparam int N1 = next_state(16'(PATTERN), SEQ_LEN, g, 1'b1);
            assign nxt0[g]    = SW'(N0);
            assign nxt1[g]    = SW'(N1);
            assign exp_tab[g] = PATTERN[SEQ_LEN-1-g];
        end else begin : g_pad
            assign nxt0[g]    = '0;
            assign nxt1[g]    = '0;
            assign exp_tab[g] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        dout    = 1'b0;
        if (!reset && en) begin
            if ((state_q == LAST) && (din == exp_tab[state_q])) begin
                dout    = 1'b1;
                state_d = OVERLAP ? FAIL_ST : '0;
            end else begin
                state_d = din ? nxt1[state_q] : nxt0[state_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (dout),
        .clr  (clr_cnt),
        .q    (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: four detector configurations share one stimulus stream;
// expectations come from hand tables and an independent shift-window model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset, en, din, clr_cnt;

    logic       dout_ov, dout_nov, dout_ones, dout_sat;
    logic [7:0] cnt_ov, cnt_nov, cnt_ones;
    logic [1:0] cnt_sat;
    logic [1:0] st_ov, st_nov, st_ones, st_sat;

    always #5 clk = ~clk;

    seq_detect_param u_ov (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
        .dout(dout_ov), .match_cnt(cnt_ov), .state_o(st_ov)
    );
    seq_detect_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
        .dout(dout_nov), .match_cnt(cnt_nov), .state_o(st_nov)
    );
    seq_detect_param #(.PATTERN(4'b1111)) u_ones (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
        .dout(dout_ones), .match_cnt(cnt_ones), .state_o(st_ones)
    );
    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
        .dout(dout_sat), .match_cnt(cnt_sat), .state_o(st_sat)
    );

    // d[0]=ov, d[1]=nov, d[2]=ones, d[3]=sat
    typedef struct {
        logic rst; logic en; logic din; logic clr;
        logic dov; logic dnov; logic dones; logic [1:0] st;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        int c0; int c1; int c2; int c3;
        logic chk_st; logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_cnt[4];
    int   c_max[4]  = '{255, 255, 255, 3};

    logic [3:0] w_pat[4] = '{4'b1011, 4'b1011, 4'b1111, 4'b1011};
    bit         w_ov[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] w_hist[4];
    int         w_valid[4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic d, input logic c,
                                input logic o, input logic n, input logic w,
                                input logic [1:0] s);
        vec_t v;
        v.rst = r; v.en = e; v.din = d; v.clr = c;
        v.dov = o; v.dnov = n; v.dones = w; v.st = s;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic push(input logic r, input logic e, input logic d, input logic c,
                        input logic [3:0] dexp, input logic cs, input logic [1:0] s);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r; en = e; din = d; clr_cnt = c;
        x.d = dexp; x.chk_st = cs; x.st = s;
        x.c0 = m_cnt[0]; x.c1 = m_cnt[1]; x.c2 = m_cnt[2]; x.c3 = m_cnt[3];
        sb.push_back(x);
        for (int j = 0; j < 4; j++) begin
            if (r || c) m_cnt[j] = 0;
            else if (dexp[j] && m_cnt[j] < c_max[j]) m_cnt[j]++;
        end
    endtask

    // Reference: match whenever the last four consumed bits equal the pattern.
    task automatic win_step(input logic r, input logic e, input logic d, output logic [3:0] o);
        for (int j = 0; j < 4; j++) begin
            o[j] = !r && e && (w_valid[j] >= 3) && ({w_hist[j][2:0], d} == w_pat[j]);
            if (r) w_valid[j] = 0;
            else if (e) begin
                w_hist[j] = {w_hist[j][2:0], d};
                w_valid[j]++;
                if (o[j] && !w_ov[j]) w_valid[j] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("dout_ov", dout_ov, x.d[0]);
            chk("dout_nov", dout_nov, x.d[1]);
            chk("dout_ones", dout_ones, x.d[2]);
            chk("dout_sat", dout_sat, x.d[3]);
            chk("cnt_ov", cnt_ov, x.c0);
            chk("cnt_nov", cnt_nov, x.c1);
            chk("cnt_ones", cnt_ones, x.c2);
            chk("cnt_sat", cnt_sat, x.c3);
            if (x.chk_st) chk("state_ov", st_ov, x.st);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        vec_t v;
        reset = 1'b1; en = 1'b1; din = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", st_ov, 0);
        chk("rst_cnt_ov", cnt_ov, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
        chk("rst_dout", dout_ov, 0);
        for (int j = 0; j < 4; j++) m_cnt[j] = 0;

        // 1011011 overlap vs non-overlap vs 1111 pattern
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
        // seven 1s
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 1, 1, 0, 0, 0, (i >= 3), (i == 0) ? 2'd0 : 2'd1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
        // enable hold with din toggling, then resume
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 3));
        // mid-sequence reset discards partial match
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 3));

        foreach (tbl[i]) begin
            v = tbl[i];
            push(v.rst, v.en, v.din, v.clr, {v.dov, v.dones, v.dnov, v.dov}, 1'b1, v.st);
        end

        // Six overlapping matches; clear coincides with the sixth.
        push(1, 1, 1, 0, 4'b0000, 1'b1, 2'd1);
        push(0, 1, 1, 0, 4'b0000, 1'b1, 2'd0);
        push(0, 1, 0, 0, 4'b0000, 1'b1, 2'd1);
        push(0, 1, 1, 0, 4'b0000, 1'b1, 2'd2);
        for (int m = 1; m <= 6; m++) begin
            push(0, 1, 1, (m == 6), {1'b1, 1'b0, 1'(m % 2), 1'b1}, 1'b1, 2'd3);
            if (m < 6) begin
                push(0, 1, 0, 0, 4'b0000, 1'b1, 2'd1);
                push(0, 1, 1, 0, 4'b0000, 1'b1, 2'd2);
            end
        end
        push(0, 0, 0, 0, 4'b0000, 1'b1, 2'd1);

        // Random traffic against the shift-window model.
        win_step(1'b1, 1'b1, 1'b0, d);
        push(1, 1, 0, 0, d, 1'b0, 2'd0);
        for (int i = 0; i < 400; i++) begin
            logic r, e, b, c;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) < 8);
            b = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 49) == 0);
            win_step(r, e, b, d);
            push(r, e, b, c, d, 1'b0, 2'd0);
        end

        @(negedge clk);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011, width SEQ_LEN: target sequence, MSB received first.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-007 SHALL have port en, input, 1: when 1, din is consumed this cycle; when 0, the FSM holds.
REQ-008 SHALL have port din, input, 1: serial data bit.
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of match_cnt.
REQ-010 SHALL have port dout, output, 1: Mealy match flag, combinational from state, en and din.
REQ-011 SHALL have port match_cnt, output, CNT_W: saturating count of detected matches.
REQ-012 SHALL have port state_o, output, clog2(SEQ_LEN): current matched-prefix length, for debug.

Function
REQ-013 State s SHALL equal the number of leading PATTERN bits currently matched, range 0..SEQ_LEN-1.
REQ-014 Expected bit in state s SHALL be PATTERN[SEQ_LEN-1-s].
REQ-015 With en=1, din=expected and s<SEQ_LEN-1, next state SHALL be s+1.
REQ-016 With en=1 and din!=expected, next state SHALL be the longest k<=s such that PATTERN's first k bits equal the last k bits of (matched prefix followed by din); this is a full DFA, not a reset to 0.
REQ-017 With en=1, s=SEQ_LEN-1 and din=expected, dout SHALL be 1 in that same cycle; zero latency, Mealy.
REQ-018 On a match with OVERLAP=1, next state SHALL be the longest proper prefix of PATTERN that is also a suffix of it (failure value, fixed at elaboration).
REQ-019 On a match with OVERLAP=0, next state SHALL be 0.
REQ-020 With en=0, state SHALL hold and dout SHALL be 0 regardless of din.
REQ-021 dout SHALL be 0 in every case not covered by REQ-017.
REQ-022 match_cnt SHALL increment by 1 on the clk edge that ends a cycle where dout=1.
REQ-023 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 If clr_cnt=1 and a match occur in the same cycle, match_cnt SHALL become 0; clear wins.
REQ-025 All next-state tables SHALL be computed at elaboration from PATTERN. No runtime pattern load.
REQ-026 Next-state and output logic SHALL assign every signal on every path; no inferred latches.

Reset
REQ-027 On reset=1 at a clk edge: state SHALL be 0 and match_cnt SHALL be 0.
REQ-028 While reset=1, dout SHALL be forced to 0.
REQ-029 Reset SHALL take priority over en and clr_cnt.
REQ-030 Reset asserted mid-sequence SHALL discard any partial match; detection restarts from the first bit after reset deasserts.

Structure
REQ-031 A shared package seq_detect_pkg SHALL hold:
- the clog2 helper;
- the prefix/suffix failure-function used to build next-state tables;
- the default PATTERN and SEQ_LEN constants.
REQ-032 The match counter SHALL be a sub-module sat_counter, parameter CNT_W, with ports clk, reset, inc, clr, q.
REQ-033 State register SHALL be a single clocked process; next-state/dout logic SHALL be a separate combinational process.

Verification
REQ-034 Default params, OVERLAP=1, en=1, din 1,0,1,1,0,1,1 -> dout=1 on bits 4 and 7, match_cnt=2.
REQ-035 Same stream with OVERLAP=0 -> dout=1 on bit 4 only; bit-7 window not matched; match_cnt=1.
REQ-036 PATTERN=4'b1111, OVERLAP=1, din seven 1s -> dout=1 on bits 4,5,6,7, match_cnt=4.
REQ-037 Default params, din 1,0,1 then en=0 for 3 cycles with din toggling, then en=1 and din=1 -> dout=0 while en=0, dout=1 on the resumed bit.
REQ-038 din 1,0,1, then reset pulse, then 1 -> no match; then 1,0,1,1 -> match; state_o=0 immediately after reset.
REQ-039 CNT_W=2, six matches, clr_cnt asserted together with the 6th match -> match_cnt 1,2,3,3,3, then 0.
